// File: rtl/downconverter_pkg.sv
// downconverter_pkg: shared types, defaults and helpers for the fs/4 downconverter demodulator.
// Holds the DECIM_LOG2 default, the output width derivation, the output stage
// state enum and the bit-to-bipolar mapping b().
package downconverter_pkg;

    localparam int DECIM_LOG2_DEF = 6;

    typedef enum logic {EMPTY, FULL} state_t;

    // Signed width needed to hold +/-2^(d+1) without saturation.
    function automatic int out_w(input int d);
        return d + 3;
    endfunction

    // Map a serial bit onto +1 / -1.
    function automatic logic signed [2:0] b(input logic x);
        return x ? 3'sd1 : -3'sd1;
    endfunction

endpackage

// File: rtl/demod_accum.sv
// demod_accum: one-channel integrate-and-dump accumulator.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_term per-word term in {-2,0,+2};
// i_valid term is meaningful; i_dump this word closes the block; o_sum running sum including i_term.
module demod_accum
    import downconverter_pkg::*;
#(
    parameter int W = out_w(DECIM_LOG2_DEF)
)(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic signed [2:0]   i_term,
    input  logic                i_valid,
    input  logic                i_dump,
    output logic signed [W-1:0] o_sum
);

    logic signed [W-1:0] r_acc;

    assign o_sum = r_acc + {{(W-3){i_term[2]}}, i_term};

    // On a dump the completed sum leaves through o_sum and the next block starts from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_acc <= '0;
        else if (i_valid)
            r_acc <= i_dump ? '0 : o_sum;
    end

endmodule

// File: rtl/downconverter_demod.sv
// downconverter_demod: fs/4 I/Q downconverter with integrate-and-dump decimation.
// Ports: iclk clock; rst_n async active-low reset; samples 4-bit ISERDES word (bit 0 earliest);
// in_valid word strobe; out_i/out_q signed block sums; out_valid result held; out_ready consumer
// accept; overrun sticky dropped-result flag; overrun_cnt (only with
// DOWNCONVERTER_DEMOD_OVERRUN_CNT_EN) saturating count of dropped results.
module downconverter_demod
    import downconverter_pkg::*;
#(
    parameter  int DECIM_LOG2 = DECIM_LOG2_DEF,
    localparam int OUT_W      = out_w(DECIM_LOG2)
)(
    input  logic                    iclk,
    input  logic                    rst_n,
    input  logic [3:0]              samples,
    input  logic                    in_valid,
    output logic signed [OUT_W-1:0] out_i,
    output logic signed [OUT_W-1:0] out_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
`ifdef DOWNCONVERTER_DEMOD_OVERRUN_CNT_EN
    ,
    output logic [15:0]             overrun_cnt
`endif
);

    logic [DECIM_LOG2-1:0]   r_cnt;
    state_t                  r_state;
    logic                    w_dump;
    logic signed [2:0]       w_term_i;
    logic signed [2:0]       w_term_q;
    logic signed [OUT_W-1:0] w_sum_i;
    logic signed [OUT_W-1:0] w_sum_q;

    // Undo the I, ~Q, ~I, Q mixing sequence.
    assign w_term_i  = b(samples[0]) - b(samples[2]);
    assign w_term_q  = b(samples[3]) - b(samples[1]);
    assign w_dump    = in_valid && (&r_cnt);
    assign out_valid = (r_state == FULL);

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (in_valid)
            r_cnt <= r_cnt + 1'b1;
    end

    demod_accum #(.W(OUT_W)) u_acc_i (
        .i_clk   (iclk),
        .i_rst_n (rst_n),
        .i_term  (w_term_i),
        .i_valid (in_valid),
        .i_dump  (w_dump),
        .o_sum   (w_sum_i)
    );

    demod_accum #(.W(OUT_W)) u_acc_q (
        .i_clk   (iclk),
        .i_rst_n (rst_n),
        .i_term  (w_term_q),
        .i_valid (in_valid),
        .i_dump  (w_dump),
        .o_sum   (w_sum_q)
    );

    // Output stage: a dump loads when empty or when the held result leaves on the same edge;
    // otherwise the new result is dropped and the held one stays untouched.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            out_i   <= '0;
            out_q   <= '0;
            overrun <= 1'b0;
`ifdef DOWNCONVERTER_DEMOD_OVERRUN_CNT_EN
            overrun_cnt <= '0;
`endif
        end else if (w_dump && (r_state == EMPTY || out_ready)) begin
            r_state <= FULL;
            out_i   <= w_sum_i;
            out_q   <= w_sum_q;
        end else if (w_dump) begin
            overrun <= 1'b1;
`ifdef DOWNCONVERTER_DEMOD_OVERRUN_CNT_EN
            if (overrun_cnt != 16'hFFFF)
                overrun_cnt <= overrun_cnt + 1'b1;
`endif
        end else if (out_ready) begin
            r_state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_downconverter_demod.sv
// tb_downconverter_demod: scoreboard bench for downconverter_demod at DECIM_LOG2=2.
module tb_downconverter_demod;

    localparam int D = 2;
    localparam int N = 1 << D;
    localparam int W = D + 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [3:0]          samples = 4'b0;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] out_i;
    logic signed [W-1:0] out_q;
    logic                out_valid;
    logic                overrun;
`ifdef DOWNCONVERTER_DEMOD_OVERRUN_CNT_EN
    logic [15:0]         overrun_cnt;
`endif

    always #5 clk = ~clk;

    downconverter_demod #(.DECIM_LOG2(D)) dut (
        .iclk      (clk),
        .rst_n     (rst_n),
        .samples   (samples),
        .in_valid  (in_valid),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
`ifdef DOWNCONVERTER_DEMOD_OVERRUN_CNT_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    typedef struct {int i; int q;} res_t;
    res_t q_exp[$];
    res_t m_r;
    int   checks = 0;
    int   failures = 0;
    bit   m_full, m_ovr, m_dump;
    int   m_ovcnt, m_sum_i, m_sum_q, m_n;

    function automatic int bm(input logic x);
        return x ? 1 : -1;
    endfunction

    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", n, got, exp, $time);
        end
    endtask

    // Reference model: block sums of 4 words, one-deep output holding slot.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_full = 0; m_ovr = 0; m_ovcnt = 0;
            m_sum_i = 0; m_sum_q = 0; m_n = 0;
            q_exp.delete();
        end else begin
            m_dump = 0;
            if (in_valid) begin
                m_sum_i += bm(samples[0]) - bm(samples[2]);
                m_sum_q += bm(samples[3]) - bm(samples[1]);
                m_n++;
                if (m_n == N) begin
                    m_dump = 1;
                    m_r = '{m_sum_i, m_sum_q};
                    m_sum_i = 0; m_sum_q = 0; m_n = 0;
                end
            end
            if (m_dump && m_full && !out_ready) begin
                m_ovr = 1;
                if (m_ovcnt < 65535) m_ovcnt++;
            end else if (m_dump) begin
                q_exp.push_back(m_r);
                m_full = 1;
            end else if (out_ready) begin
                m_full = 0;
            end
        end
    end

    // Monitor: compares whatever the DUT presents, pops on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", int'(out_valid), int'(m_full));
            chk("overrun", int'(overrun), int'(m_ovr));
`ifdef DOWNCONVERTER_DEMOD_OVERRUN_CNT_EN
            chk("overrun_cnt", int'(overrun_cnt), m_ovcnt);
`endif
            if (out_valid && q_exp.size() > 0) begin
                chk("out_i", int'(out_i), q_exp[0].i);
                chk("out_q", int'(out_q), q_exp[0].q);
                if (out_ready) void'(q_exp.pop_front());
            end
        end
    end

    task automatic step(input logic [3:0] s, input logic v, input logic r);
        @(posedge clk);
        #1;
        samples = s; in_valid = v; out_ready = r;
    endtask

    task automatic reset_pulse(input string n);
        @(posedge clk);
        #1;
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk({n, "_i"}, int'(out_i), 0);
        chk({n, "_q"}, int'(out_q), 0);
        chk({n, "_valid"}, int'(out_valid), 0);
        chk({n, "_overrun"}, int'(overrun), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input string n, input int ei, input int eq, input int eo);
        @(negedge clk);
        chk({n, "_valid"}, int'(out_valid), 1);
        chk({n, "_i"}, int'(out_i), ei);
        chk({n, "_q"}, int'(out_q), eq);
        chk({n, "_overrun"}, int'(overrun), eo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset_pulse("reset");

        repeat (4) step(4'b1001, 1, 1);
        step(4'b0, 0, 1);
        expect_out("pos_pos", 8, 8, 0);

        repeat (4) step(4'b0110, 1, 1);
        step(4'b0, 0, 1);
        expect_out("neg_neg", -8, -8, 0);

        repeat (4) step(4'b0001, 1, 1);
        step(4'b0, 0, 1);
        expect_out("pos_zero", 8, 0, 0);

        repeat (4) begin
            step(4'b1001, 1, 1);
            step(4'b0, 0, 1);
        end
        expect_out("gapped", 8, 8, 0);

        repeat (4) step(4'b1001, 1, 0);
        repeat (3) step(4'b0110, 1, 0);
        step(4'b0110, 1, 1);
        step(4'b0, 0, 0);
        expect_out("dump_on_accept", -8, -8, 0);
        step(4'b0, 0, 1);

        repeat (4) step(4'b1001, 1, 0);
        repeat (4) step(4'b0110, 1, 0);
        step(4'b0, 0, 0);
        expect_out("overrun_hold", 8, 8, 1);
`ifdef DOWNCONVERTER_DEMOD_OVERRUN_CNT_EN
        chk("overrun_cnt_one", int'(overrun_cnt), 1);
`endif
        step(4'b0, 0, 1);

        repeat (2) step(4'b1001, 1, 1);
        reset_pulse("mid_reset");
        repeat (4) step(4'b1001, 1, 1);
        step(4'b0, 0, 1);
        expect_out("after_reset", 8, 8, 0);

        repeat (600) step(4'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);

        repeat (3) step(4'b0, 0, 1);
        @(negedge clk);
        chk("drain_empty", q_exp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
